// File: rtl/axil_bram_port_ctrl_pkg.sv
// Shared definitions for the AXI4-Lite to BRAM port controller:
// response codes, FSM state encoding and word-index sizing.
package prism_axil_pkg;

   localparam logic [1:0] RESP_OKAY = 2'b00;

   // Byte-offset bits below the word index; the index starts at address bit 2.
   localparam int unsigned WORD_BYTE_OFS_W = 2;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WR_RESP = 2'd1,
      ST_RD_WAIT = 2'd2,
      ST_RD_RESP = 2'd3
   } state_e;

   function automatic int unsigned word_idx_w(input int unsigned lines);
      return $clog2(lines);
   endfunction

endpackage

// File: rtl/axil_bram_port_ctrl_if.sv
// AXI4-Lite slave bus plus BRAM initiator port of the controller.
// The slave modport is the controller; the master modport is the environment.
interface axil_bram_port_ctrl_if #(
   parameter int unsigned LINES       = 4096,
   parameter int unsigned AXIL_ADDR_W = 32,
   parameter int unsigned XLEN        = 32
);
   localparam int unsigned IDX_W = $clog2(LINES);

   logic [AXIL_ADDR_W-1:0] s_axil_awaddr;
   logic                   s_axil_awvalid;
   logic                   s_axil_awready;
   logic [XLEN-1:0]        s_axil_wdata;
   logic [XLEN/8-1:0]      s_axil_wstrb;
   logic                   s_axil_wvalid;
   logic                   s_axil_wready;
   logic [1:0]             s_axil_bresp;
   logic                   s_axil_bvalid;
   logic                   s_axil_bready;
   logic [AXIL_ADDR_W-1:0] s_axil_araddr;
   logic                   s_axil_arvalid;
   logic                   s_axil_arready;
   logic [XLEN-1:0]        s_axil_rdata;
   logic [1:0]             s_axil_rresp;
   logic                   s_axil_rvalid;
   logic                   s_axil_rready;
   logic [IDX_W-1:0]       bram_addr;
   logic                   bram_en;
   logic [XLEN/8-1:0]      bram_be;
   logic [XLEN-1:0]        bram_din;
   logic [XLEN-1:0]        bram_dout;

   modport slave (
      input  s_axil_awaddr, s_axil_awvalid, s_axil_wdata, s_axil_wstrb, s_axil_wvalid,
      input  s_axil_bready, s_axil_araddr, s_axil_arvalid, s_axil_rready, bram_dout,
      output s_axil_awready, s_axil_wready, s_axil_bresp, s_axil_bvalid,
      output s_axil_arready, s_axil_rdata, s_axil_rresp, s_axil_rvalid,
      output bram_addr, bram_en, bram_be, bram_din
   );

   modport master (
      output s_axil_awaddr, s_axil_awvalid, s_axil_wdata, s_axil_wstrb, s_axil_wvalid,
      output s_axil_bready, s_axil_araddr, s_axil_arvalid, s_axil_rready, bram_dout,
      input  s_axil_awready, s_axil_wready, s_axil_bresp, s_axil_bvalid,
      input  s_axil_arready, s_axil_rdata, s_axil_rresp, s_axil_rvalid,
      input  bram_addr, bram_en, bram_be, bram_din
   );

endinterface

// File: rtl/axil_bram_port_ctrl.sv
// AXI4-Lite slave driving one port of a byte-enable BRAM, one transaction
// at a time, with fair read/write arbitration and a registered R channel.
module axil_bram_port_ctrl
   import prism_axil_pkg::*;
#(
   parameter int unsigned LINES       = 4096,
   parameter int unsigned AXIL_ADDR_W = 32,
   parameter int unsigned XLEN        = 32
) (
   input  logic                 clk,
   input  logic                 rstn,
   axil_bram_port_ctrl_if.slave bus
);
   localparam int unsigned IDX_W = word_idx_w(LINES);

   state_e          state_q, state_d;
   logic            last_wr_q, last_wr_d;
   logic [XLEN-1:0] rdata_q, rdata_d;
   logic            wr_elig_s, rd_elig_s;
   logic            grant_wr_s, grant_rd_s;

   // Arbitration: a write needs AW and W together; ties go to the side not granted last.
   always_comb begin
      wr_elig_s = bus.s_axil_awvalid && bus.s_axil_wvalid;
      rd_elig_s = bus.s_axil_arvalid;
      if (state_q == ST_IDLE) begin
         grant_wr_s = wr_elig_s && (!rd_elig_s || !last_wr_q);
         grant_rd_s = rd_elig_s && (!wr_elig_s || last_wr_q);
      end else begin
         grant_wr_s = 1'b0;
         grant_rd_s = 1'b0;
      end
   end

   // State, arbitration history and read-data registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= ST_IDLE;
         last_wr_q <= 1'b0;
         rdata_q   <= {XLEN{1'b0}};
      end else begin
         state_q   <= state_d;
         last_wr_q <= last_wr_d;
         rdata_q   <= rdata_d;
      end
   end

   // Next-state logic; read data is captured the cycle after the BRAM is enabled.
   always_comb begin
      state_d   = state_q;
      last_wr_d = last_wr_q;
      rdata_d   = rdata_q;
      case (state_q)
         ST_IDLE: begin
            if (grant_wr_s) begin
               state_d   = ST_WR_RESP;
               last_wr_d = 1'b1;
            end else if (grant_rd_s) begin
               state_d   = ST_RD_WAIT;
               last_wr_d = 1'b0;
            end else begin
               state_d   = ST_IDLE;
            end
         end
         ST_WR_RESP: begin
            if (bus.s_axil_bready) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_WR_RESP;
            end
         end
         ST_RD_WAIT: begin
            rdata_d = bus.bram_dout;
            state_d = ST_RD_RESP;
         end
         ST_RD_RESP: begin
            if (bus.s_axil_rready) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_RD_RESP;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Grant-cycle outputs: readies and the BRAM access itself.
   always_comb begin
      bus.s_axil_awready = grant_wr_s;
      bus.s_axil_wready  = grant_wr_s;
      bus.s_axil_arready = grant_rd_s;
      bus.bram_en        = grant_wr_s || grant_rd_s;
      if (grant_wr_s) begin
         bus.bram_addr = IDX_W'(bus.s_axil_awaddr >> WORD_BYTE_OFS_W);
         bus.bram_be   = bus.s_axil_wstrb;
         bus.bram_din  = bus.s_axil_wdata;
      end else if (grant_rd_s) begin
         bus.bram_addr = IDX_W'(bus.s_axil_araddr >> WORD_BYTE_OFS_W);
         bus.bram_be   = {(XLEN/8){1'b0}};
         bus.bram_din  = {XLEN{1'b0}};
      end else begin
         bus.bram_addr = {IDX_W{1'b0}};
         bus.bram_be   = {(XLEN/8){1'b0}};
         bus.bram_din  = {XLEN{1'b0}};
      end
   end

   assign bus.s_axil_bvalid = (state_q == ST_WR_RESP);
   assign bus.s_axil_rvalid = (state_q == ST_RD_RESP);
   assign bus.s_axil_rdata  = rdata_q;
   assign bus.s_axil_bresp  = RESP_OKAY;
   assign bus.s_axil_rresp  = RESP_OKAY;

endmodule

// File: tb/tb_axil_bram_port_ctrl.sv
// Directed bench for axil_bram_port_ctrl with a read-first byte-enable BRAM model.
module tb_axil_bram_port_ctrl;
   localparam int unsigned LINES = 4096;
   localparam int unsigned AW    = 32;
   localparam int unsigned XLEN  = 32;

   logic clk;
   logic rstn;
   int   total;
   int   bad;
   logic [31:0] mem [0:LINES-1];

   axil_bram_port_ctrl_if #(.LINES(LINES), .AXIL_ADDR_W(AW), .XLEN(XLEN)) bus ();

   axil_bram_port_ctrl #(.LINES(LINES), .AXIL_ADDR_W(AW), .XLEN(XLEN)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // BRAM model: byte-enable write, read data one cycle after enable.
   always @(posedge clk) begin
      if (bus.bram_en) begin
         for (int b = 0; b < 4; b++) begin
            if (bus.bram_be[b]) mem[bus.bram_addr][b*8 +: 8] <= bus.bram_din[b*8 +: 8];
         end
         bus.bram_dout <= mem[bus.bram_addr];
      end
   end

   task automatic idle_inputs();
      bus.s_axil_awaddr = 32'h0; bus.s_axil_awvalid = 1'b0;
      bus.s_axil_wdata = 32'h0; bus.s_axil_wstrb = 4'h0; bus.s_axil_wvalid = 1'b0;
      bus.s_axil_bready = 1'b0; bus.s_axil_araddr = 32'h0;
      bus.s_axil_arvalid = 1'b0; bus.s_axil_rready = 1'b0;
   endtask

   task automatic apply_reset();
      @(negedge clk); rstn = 1'b0; idle_inputs();
      @(negedge clk); @(negedge clk); rstn = 1'b1;
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      int n;
      @(negedge clk);
      bus.s_axil_awaddr = a; bus.s_axil_wdata = d; bus.s_axil_wstrb = s;
      bus.s_axil_awvalid = 1'b1; bus.s_axil_wvalid = 1'b1; bus.s_axil_bready = 1'b1;
      n = 0; #1;
      while (!bus.s_axil_awready && n < 20) begin @(negedge clk); #1; n++; end
      total++;
      if (n >= 20) begin bad++; $display("FAIL wr_aw_timeout got %0d exp <20", n); end
      @(negedge clk);
      bus.s_axil_awvalid = 1'b0; bus.s_axil_wvalid = 1'b0;
      n = 0; #1;
      while (!bus.s_axil_bvalid && n < 20) begin @(negedge clk); #1; n++; end
      total++;
      if (n >= 20) begin bad++; $display("FAIL wr_b_timeout got %0d exp <20", n); end
      @(negedge clk); bus.s_axil_bready = 1'b0;
   endtask

   task automatic do_read(input logic [31:0] a, output logic [31:0] d);
      int n;
      @(negedge clk);
      bus.s_axil_araddr = a; bus.s_axil_arvalid = 1'b1; bus.s_axil_rready = 1'b1;
      n = 0; #1;
      while (!bus.s_axil_arready && n < 20) begin @(negedge clk); #1; n++; end
      total++;
      if (n >= 20) begin bad++; $display("FAIL rd_ar_timeout got %0d exp <20", n); end
      @(negedge clk);
      bus.s_axil_arvalid = 1'b0;
      n = 0; #1;
      while (!bus.s_axil_rvalid && n < 20) begin @(negedge clk); #1; n++; end
      total++;
      if (n >= 20) begin bad++; $display("FAIL rd_r_timeout got %0d exp <20", n); end
      d = bus.s_axil_rdata;
      @(negedge clk); bus.s_axil_rready = 1'b0;
   endtask

   task automatic test_reset();
      rstn = 1'b0; idle_inputs();
      @(negedge clk); @(negedge clk);
      total++;
      if ({bus.s_axil_awready, bus.s_axil_wready, bus.s_axil_arready} !== 3'b000) begin
         bad++; $display("FAIL reset_readies got %b exp 000",
                         {bus.s_axil_awready, bus.s_axil_wready, bus.s_axil_arready});
      end
      total++;
      if ({bus.s_axil_bvalid, bus.s_axil_rvalid} !== 2'b00) begin
         bad++; $display("FAIL reset_valids got %b exp 00", {bus.s_axil_bvalid, bus.s_axil_rvalid});
      end
      total++;
      if (bus.s_axil_rdata !== 32'h0) begin
         bad++; $display("FAIL reset_rdata got %h exp 00000000", bus.s_axil_rdata);
      end
      total++;
      if ({bus.s_axil_bresp, bus.s_axil_rresp} !== 4'b0000) begin
         bad++; $display("FAIL reset_resp got %b exp 0000", {bus.s_axil_bresp, bus.s_axil_rresp});
      end
      total++;
      if ({bus.bram_en, bus.bram_be} !== 5'b00000) begin
         bad++; $display("FAIL reset_bram got %b exp 00000", {bus.bram_en, bus.bram_be});
      end
      rstn = 1'b1;
   endtask

   task automatic test_write_basic();
      @(negedge clk);
      bus.s_axil_awaddr = 32'h10; bus.s_axil_wdata = 32'hDEADBEEF; bus.s_axil_wstrb = 4'hF;
      bus.s_axil_awvalid = 1'b1; bus.s_axil_wvalid = 1'b1; bus.s_axil_bready = 1'b0;
      #1;
      total++;
      if ({bus.s_axil_awready, bus.s_axil_wready, bus.bram_en} !== 3'b111) begin
         bad++; $display("FAIL wr_handshake got %b exp 111",
                         {bus.s_axil_awready, bus.s_axil_wready, bus.bram_en});
      end
      total++;
      if (bus.bram_addr !== 12'd4 || bus.bram_be !== 4'hF || bus.bram_din !== 32'hDEADBEEF) begin
         bad++; $display("FAIL wr_bram_port got addr=%0d be=%h din=%h exp addr=4 be=f din=deadbeef",
                         bus.bram_addr, bus.bram_be, bus.bram_din);
      end
      total++;
      if (bus.s_axil_bvalid !== 1'b0) begin
         bad++; $display("FAIL wr_bvalid_T got %b exp 0", bus.s_axil_bvalid);
      end
      @(negedge clk);
      bus.s_axil_awvalid = 1'b0; bus.s_axil_wvalid = 1'b0;
      #1;
      total++;
      if (bus.s_axil_bvalid !== 1'b1 || bus.s_axil_bresp !== 2'b00) begin
         bad++; $display("FAIL wr_bvalid_T1 got bvalid=%b bresp=%b exp 1/00",
                         bus.s_axil_bvalid, bus.s_axil_bresp);
      end
      total++;
      if (mem[4] !== 32'hDEADBEEF) begin
         bad++; $display("FAIL wr_mem got %h exp deadbeef", mem[4]);
      end
      for (int c = 0; c < 2; c++) begin
         @(negedge clk); #1;
         total++;
         if (bus.s_axil_bvalid !== 1'b1 || bus.bram_en !== 1'b0) begin
            bad++; $display("FAIL wr_b_hold got bvalid=%b en=%b exp 1/0", bus.s_axil_bvalid, bus.bram_en);
         end
      end
      bus.s_axil_bready = 1'b1;
      @(negedge clk); #1;
      total++;
      if (bus.s_axil_bvalid !== 1'b0) begin
         bad++; $display("FAIL wr_b_done got %b exp 0", bus.s_axil_bvalid);
      end
      bus.s_axil_bready = 1'b0;
   endtask

   task automatic test_read_backpressure();
      @(negedge clk);
      bus.s_axil_araddr = 32'h10; bus.s_axil_arvalid = 1'b1; bus.s_axil_rready = 1'b0;
      #1;
      total++;
      if (bus.s_axil_arready !== 1'b1 || bus.bram_en !== 1'b1 || bus.bram_be !== 4'h0 ||
          bus.bram_addr !== 12'd4) begin
         bad++; $display("FAIL rd_handshake got ar=%b en=%b be=%h addr=%0d exp 1/1/0/4",
                         bus.s_axil_arready, bus.bram_en, bus.bram_be, bus.bram_addr);
      end
      @(negedge clk);
      bus.s_axil_arvalid = 1'b0;
      #1;
      total++;
      if (bus.s_axil_rvalid !== 1'b0) begin
         bad++; $display("FAIL rd_rvalid_T1 got %b exp 0", bus.s_axil_rvalid);
      end
      for (int c = 0; c < 6; c++) begin
         @(negedge clk); #1;
         total++;
         if (bus.s_axil_rvalid !== 1'b1 || bus.s_axil_rdata !== 32'hDEADBEEF ||
             bus.s_axil_rresp !== 2'b00) begin
            bad++; $display("FAIL rd_hold cycle %0d got rvalid=%b rdata=%h exp 1/deadbeef",
                            c, bus.s_axil_rvalid, bus.s_axil_rdata);
         end
      end
      bus.s_axil_rready = 1'b1;
      @(negedge clk); #1;
      total++;
      if (bus.s_axil_rvalid !== 1'b0) begin
         bad++; $display("FAIL rd_done got %b exp 0", bus.s_axil_rvalid);
      end
      bus.s_axil_rready = 1'b0;
   endtask

   task automatic test_byte_strobe();
      logic [31:0] d;
      do_write(32'h20, 32'h11223344, 4'hF);
      do_write(32'h20, 32'h000000AA, 4'h1);
      do_read(32'h20, d);
      total++;
      if (d !== 32'h112233AA) begin
         bad++; $display("FAIL strobe_merge got %h exp 112233aa", d);
      end
      // Zero strobe: response still issued, memory untouched.
      @(negedge clk);
      bus.s_axil_awaddr = 32'h20; bus.s_axil_wdata = 32'hFFFFFFFF; bus.s_axil_wstrb = 4'h0;
      bus.s_axil_awvalid = 1'b1; bus.s_axil_wvalid = 1'b1; bus.s_axil_bready = 1'b1;
      #1;
      total++;
      if (bus.s_axil_awready !== 1'b1 || bus.bram_be !== 4'h0) begin
         bad++; $display("FAIL strobe_zero_be got awready=%b be=%h exp 1/0", bus.s_axil_awready, bus.bram_be);
      end
      @(negedge clk);
      bus.s_axil_awvalid = 1'b0; bus.s_axil_wvalid = 1'b0;
      #1;
      total++;
      if (bus.s_axil_bvalid !== 1'b1) begin
         bad++; $display("FAIL strobe_zero_b got %b exp 1", bus.s_axil_bvalid);
      end
      @(negedge clk); bus.s_axil_bready = 1'b0;
      do_read(32'h4023, d);
      total++;
      if (d !== 32'h112233AA) begin
         bad++; $display("FAIL alias_read got %h exp 112233aa", d);
      end
   endtask

   task automatic test_arbitration();
      bit q[$];
      int both;
      both = 0;
      apply_reset();
      @(negedge clk);
      bus.s_axil_awaddr = 32'h40; bus.s_axil_wdata = 32'hCAFE0001; bus.s_axil_wstrb = 4'hF;
      bus.s_axil_araddr = 32'h10;
      bus.s_axil_awvalid = 1'b1; bus.s_axil_wvalid = 1'b1; bus.s_axil_arvalid = 1'b1;
      bus.s_axil_bready = 1'b1; bus.s_axil_rready = 1'b1;
      for (int c = 0; c < 20; c++) begin
         #1;
         if (bus.s_axil_awready) q.push_back(1'b1);
         if (bus.s_axil_arready) q.push_back(1'b0);
         if (bus.s_axil_awready && bus.s_axil_arready) both++;
         @(negedge clk);
      end
      idle_inputs();
      bus.s_axil_bready = 1'b1; bus.s_axil_rready = 1'b1;
      @(negedge clk); @(negedge clk);
      bus.s_axil_bready = 1'b0; bus.s_axil_rready = 1'b0;
      total++;
      if (q.size() !== 8) begin
         bad++; $display("FAIL arb_grant_count got %0d exp 8", q.size());
      end
      total++;
      if (both !== 0) begin
         bad++; $display("FAIL arb_double_grant got %0d exp 0", both);
      end
      for (int i = 0; i < 8 && i < q.size(); i++) begin
         total++;
         if (q[i] !== ((i % 2) == 0)) begin
            bad++; $display("FAIL arb_order idx %0d got wr=%b exp wr=%b", i, q[i], ((i % 2) == 0));
         end
      end
   endtask

   task automatic test_aw_without_w();
      @(negedge clk);
      bus.s_axil_awaddr = 32'h30; bus.s_axil_wdata = 32'h5A5A5A5A; bus.s_axil_wstrb = 4'hF;
      bus.s_axil_awvalid = 1'b1; bus.s_axil_wvalid = 1'b0; bus.s_axil_bready = 1'b1;
      for (int c = 0; c < 10; c++) begin
         #1;
         total++;
         if (bus.s_axil_awready !== 1'b0 || bus.s_axil_wready !== 1'b0 || bus.bram_en !== 1'b0) begin
            bad++; $display("FAIL aw_only cycle %0d got aw=%b w=%b en=%b exp 0/0/0",
                            c, bus.s_axil_awready, bus.s_axil_wready, bus.bram_en);
         end
         @(negedge clk);
      end
      bus.s_axil_wvalid = 1'b1;
      #1;
      total++;
      if (bus.s_axil_awready !== 1'b1 || bus.s_axil_wready !== 1'b1 || bus.bram_addr !== 12'd12) begin
         bad++; $display("FAIL aw_then_w got aw=%b w=%b addr=%0d exp 1/1/12",
                         bus.s_axil_awready, bus.s_axil_wready, bus.bram_addr);
      end
      @(negedge clk);
      bus.s_axil_awvalid = 1'b0; bus.s_axil_wvalid = 1'b0;
      @(negedge clk); bus.s_axil_bready = 1'b0;
      total++;
      if (mem[12] !== 32'h5A5A5A5A) begin
         bad++; $display("FAIL aw_then_w_mem got %h exp 5a5a5a5a", mem[12]);
      end
   endtask

   task automatic test_reset_mid_read();
      logic [31:0] d;
      @(negedge clk);
      bus.s_axil_araddr = 32'h10; bus.s_axil_arvalid = 1'b1; bus.s_axil_rready = 1'b0;
      @(negedge clk);
      bus.s_axil_arvalid = 1'b0;
      rstn = 1'b0;
      #1;
      total++;
      if (bus.s_axil_rvalid !== 1'b0) begin
         bad++; $display("FAIL midrst_rvalid got %b exp 0", bus.s_axil_rvalid);
      end
      @(negedge clk); rstn = 1'b1;
      @(negedge clk); #1;
      total++;
      if (bus.s_axil_rvalid !== 1'b0 || bus.s_axil_rdata !== 32'h0) begin
         bad++; $display("FAIL midrst_idle got rvalid=%b rdata=%h exp 0/00000000",
                         bus.s_axil_rvalid, bus.s_axil_rdata);
      end
      do_read(32'h10, d);
      total++;
      if (d !== 32'hDEADBEEF) begin
         bad++; $display("FAIL midrst_next_read got %h exp deadbeef", d);
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_write_basic();
      test_read_backpressure();
      test_byte_strobe();
      test_arbitration();
      test_aw_without_w();
      test_reset_mid_read();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/axil_bram_port_ctrl.md
# axil_bram_port_ctrl

AXI4-Lite slave that acts as the initiator on one port of a byte-enable dual-port BRAM, giving the control processor or host word-granular read/write access to scratchpad memory. Accepts one transaction at a time, arbitrates fairly between reads and writes, and absorbs the BRAM's 1-cycle read latency behind a registered R channel. Sits between the AXI4-Lite interconnect and the BRAM port; the other BRAM port stays with the datapath.

## Interface
- LINES, 4096, BRAM depth in XLEN-bit words; power of two
- AXIL_ADDR_W, 32, AXI byte-address width
- clk  in  1  clock
- rstn  in  1  asynchronous, active-low reset
- s_axil_awaddr  in  AXIL_ADDR_W  write byte address
- s_axil_awvalid / s_axil_awready  in / out  1  AW handshake
- s_axil_wdata  in  XLEN  write data
- s_axil_wstrb  in  XLEN/8  byte strobes
- s_axil_wvalid / s_axil_wready  in / out  1  W handshake
- s_axil_bresp  out  2  always OKAY (2'b00)
- s_axil_bvalid / s_axil_bready  out / in  1  B handshake
- s_axil_araddr  in  AXIL_ADDR_W  read byte address
- s_axil_arvalid / s_axil_arready  in / out  1  AR handshake
- s_axil_rdata  out  XLEN  read data (registered)
- s_axil_rresp  out  2  always OKAY
- s_axil_rvalid / s_axil_rready  out / in  1  R handshake
- bram_addr  out  $clog2(LINES)  word index
- bram_en  out  1  port enable
- bram_be  out  XLEN/8  byte enables; all-zero for reads
- bram_din  out  XLEN  write data
- bram_dout  in  XLEN  read data, valid 1 cycle after bram_en

## Operation
- States: IDLE, WR_RESP, RD_WAIT, RD_RESP.
- Word index = addr[$clog2(LINES)+1:2]; bits [1:0] and bits above the index ignored (aliasing, no error response).
- Write eligible in IDLE only when awvalid && wvalid; AW and W never accepted separately.
- Read eligible in IDLE when arvalid.
- Both eligible: grant the one not granted last (1-bit last_was_write, reset 0 so write wins first contest).
- Write grant (IDLE): awready=wready=1 same cycle; bram_en=1, bram_be=wstrb, bram_din=wdata; -> WR_RESP.
- WR_RESP: bvalid=1; on bready -> IDLE.
- Read grant (IDLE): arready=1; bram_en=1, bram_be=0; -> RD_WAIT.
- RD_WAIT: rdata <= bram_dout; -> RD_RESP.
- RD_RESP: rvalid=1, rdata stable; on rready -> IDLE.
- wstrb=0 write: BRAM untouched (be=0), B response still issued.
- bram_en=0 and ready outputs 0 in every state except IDLE grant cycle.

## Timing
- Reset values: all readies 0, bvalid=0, rvalid=0, rdata=0, bresp=rresp=0, bram_en=0, bram_be=0, state IDLE, last_was_write=0.
- Readies are combinational from state and valids; all other AXI outputs registered.
- Write: handshake cycle T, BRAM written at T's edge, bvalid from T+1.
- Read: handshake T, rvalid from T+2.
- Max throughput with ready held high: one write per 2 cycles, one read per 3 cycles.
- bvalid/rvalid held with stable payload until accepted; backpressure of any length legal.
- Reset mid-transaction: state to IDLE immediately, pending response lost; BRAM write already issued stays committed.

## Structure
- Shared package (prism_axil_pkg): AXI resp constants (RESP_OKAY), state enum typedef, word-index helper width constant.
- No sub-module; BRAM (byte-enable dual-port) instantiated by parent and connected to the bram_* ports.

## Test plan
- Reset then write 0xDEADBEEF, wstrb=0xF, addr 0x10 -> bram_addr=4, bram_be=0xF at handshake; bvalid at T+1, bresp=0.
- Read addr 0x10 after above -> rvalid at T+2, rdata=0xDEADBEEF; rready held low 5 cycles -> rdata/rvalid stable.
- Write 0x000000AA wstrb=0x1 to word holding 0x11223344 -> read back 0x112233AA.
- awvalid and arvalid/wvalid asserted continuously together -> grants alternate W,R,W,R starting with W; neither starves.
- awvalid without wvalid for 10 cycles -> awready stays 0, no BRAM activity; then wvalid -> accepted.
- Assert rstn low during RD_WAIT -> rvalid=0, state IDLE; next read completes normally.
